// File: rtl/port_rx_framer.sv
// Serial ingress framer: start-edge detect, MSB-first shift, optional SFD check, one-entry valid/ready hold.
// Optional feature: define PORT_RX_SFD_CHECK_EN to build the delimiter comparison and sfd_err_cnt.
module port_rx_framer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int SFD_WIDTH  = 4,
  parameter logic [SFD_WIDTH-1:0] SFD = 4'b0101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_bit,
  output logic [DEPTH-1:0]      frame_out,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic [7:0]            drop_cnt,
  output logic [7:0]            sfd_err_cnt
);
  localparam int CW = $clog2(DEPTH);

  // A start edge needs a leading 0, so an SFD with MSB 1 could never be received.
  if (DEPTH < SFD_WIDTH + 2 * ADDR_WIDTH + 1 || SFD[SFD_WIDTH-1]) begin : g_bad_cfg
    $error("port_rx_framer: illegal DEPTH/ADDR_WIDTH/SFD_WIDTH/SFD combination");
  end

  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nx;

  logic             prev_bit;
  logic [CW-1:0]    bit_cnt;
  logic [DEPTH-2:0] shreg;
  logic [DEPTH-1:0] full;
  logic             start, last, sfd_ok, drain, accept;

  assign start  = (state == IDLE) && !rx_bit && prev_bit;
  assign last   = (state == RECV) && (bit_cnt == CW'(DEPTH - 1));
  assign full   = {shreg, rx_bit};
  assign drain  = frame_valid && frame_ready;
  assign accept = last && sfd_ok;

`ifdef PORT_RX_SFD_CHECK_EN
  assign sfd_ok = (full[DEPTH-1 -: SFD_WIDTH] == SFD);

  always_ff @(posedge clk) begin
    if (!rst)
      sfd_err_cnt <= '0;
    else if (last && !sfd_ok && sfd_err_cnt != 8'hFF)
      sfd_err_cnt <= sfd_err_cnt + 8'd1;
  end
`else
  assign sfd_ok      = 1'b1;
  assign sfd_err_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RECV;
      RECV:    if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_bit    <= 1'b1;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      prev_bit <= rx_bit;
      if (start || state == RECV) shreg <= {shreg[DEPTH-3:0], rx_bit};
      if (start)                  bit_cnt <= CW'(1);
      else if (last)              bit_cnt <= '0;
      else if (state == RECV)     bit_cnt <= bit_cnt + CW'(1);
      // A drain on the completion edge frees the slot for the new frame.
      if (accept && (!frame_valid || drain)) begin
        frame_out   <= full;
        frame_valid <= 1'b1;
      end else if (drain) begin
        frame_valid <= 1'b0;
      end
      if (accept && frame_valid && !drain && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign dst_addr = frame_out[DEPTH-SFD_WIDTH-1 -: ADDR_WIDTH];
  assign src_addr = frame_out[DEPTH-SFD_WIDTH-ADDR_WIDTH-1 -: ADDR_WIDTH];
endmodule
